muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit for the RISC-V core.
//   Takes rs1/rs2 from the register file and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   Drives one data input of the 32-bit writeback-select mux.
//   o_stall freezes PC and register-file write until o_valid.
// PARAMETERS
//   XLEN      32   operand/result width; only 32 is supported
//   CNT_W     5    iteration-counter width (log2 XLEN)
// PORTS
//   i_clk         in   1     clock; all state updates on the rising edge
//   i_rst         in   1     reset; asynchronous, active-high
//   i_start       in   1     M-type instruction in decode; held high by the core until o_valid
//   i_kill        in   1     abort the current operation (trap/flush)
//   i_funct3      in   3     RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_rs1_data    in   32    operand A (multiplicand/dividend)
//   i_rs2_data    in   32    operand B (multiplier/divisor)
//   o_result      out  32    result to the writeback mux; stable while o_valid=1
//   o_valid       out  1     result ready; one-cycle pulse
//   o_stall       out  1     combinational: i_start & ~o_valid
// BEHAVIOUR
//   Reset (async, any state):
//     - state=IDLE; o_result=0; o_valid=0.
//     - Counter, accumulator, quotient and operand registers cleared.
//   FSM states: IDLE, CALC, DONE.
//   IDLE
//     - Operands, funct3 and sign flags are latched when i_start=1 and i_kill=0.
//     - Special case (div-by-0, DIV overflow, or FAST_MUL_EN mul) -> DONE. All other ops -> CALC, cnt=31.
//   CALC
//     - One bit per cycle; cnt decrements.
//     - At cnt=0: sign fixup, then -> DONE.
//     - Exactly 32 CALC cycles.
//   DONE
//     - o_valid=1 for one cycle -> IDLE.
//     - i_start is still high from the same instruction and does not start a new op.
//   Latency (start cycle = 0)
//     - o_valid in cycle 33 for iterative ops.
//     - o_valid in cycle 1 for special cases.
//   Multiply
//     - Shift-add on a 64-bit accumulator using operand magnitudes.
//     - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
//     - Product is negated if the operand signs differ (signed operands only).
//     - MUL returns product[31:0]; MULH* return product[63:32].
//   Divide
//     - Restoring divide on magnitudes.
//     - Quotient is negated if the signs differ (DIV only).
//     - Remainder takes the dividend's sign (REM only).
//   Special cases (RISC-V spec)
//     - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
//     - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
//   Result hold
//     - o_result holds its value after DONE until the next completed op. It is never cleared by IDLE.
//   Abort
//     - i_kill in CALC or DONE -> IDLE on the next edge; o_valid stays 0; o_result unchanged.
//     - i_kill has priority over i_start.
//   Operand stability
//     - Input changes after capture have no effect until the next start.
// CONFIGURATION
//   FAST_MUL_EN defined
//     - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed '*' product.
//     - IDLE -> DONE directly, so o_valid arrives in cycle 1.
//     - Divides are unchanged (33 cycles).
//   FAST_MUL_EN undefined
//     - All ops use the iterative 32-cycle datapath.
// TESTING
//   1. Reset mid-CALC (cycle 10)
//      -> o_valid=0, o_result=0 and o_stall=i_start immediately, without waiting for a clock edge.
//   2. MUL 7 x 0xFFFFFFFD
//      -> o_result=0xFFFFFFEB, o_valid in cycle 33; o_stall=1 in cycles 0..32.
//   3. MULH 0x80000000 x 0x80000000 -> 0x40000000.
//      MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//      MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//   4. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
//      REM same operands -> 0xFFFFFFFF.
//      DIVU 100 / 7 -> 14.
//      REMU 100 / 7 -> 2.
//   5. DIVU 5 / 0 -> 0xFFFFFFFF, and REM 5 / 0 -> 5, both in cycle 1.
//      DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1.
//   6. i_kill at cycle 12 of a DIV
//      -> IDLE next cycle, no o_valid, o_result keeps its previous value.
//      A new start then completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// ----------------------------------------------------------------------------
// Iterative RV32M multiply/divide unit. Computes MUL, MULH, MULHSU, MULHU,
// DIV, DIVU, REM and REMU on the register-file operands and feeds one input
// of the writeback-select mux. While an operation is in flight, o_stall
// freezes the PC and the register-file write.
//
// Multiplies use shift-add and divides use restoring division. Both run on
// operand magnitudes in a shared 64-bit accumulator, one bit per cycle for
// 32 cycles. A sign fixup follows. Divide-by-zero and signed overflow finish
// in one cycle.
//
// Optional feature macro: FAST_MUL_EN
//   defined   : all multiplies use a single-cycle 33x33 signed product and
//               finish in one cycle. Divides are unchanged.
//   undefined : all operations use the iterative datapath.
//
// Ports
//   i_clk       in   1     clock, rising edge
//   i_rst       in   1     asynchronous active-high reset
//   i_start     in   1     M-type op in decode, held until o_valid
//   i_kill      in   1     abort current operation (trap/flush)
//   i_funct3    in   3     RV32M operation select
//   i_rs1_data  in   32    operand A (multiplicand / dividend)
//   i_rs2_data  in   32    operand B (multiplier / divisor)
//   o_result    out  32    result, held until the next completed op
//   o_valid     out  1     one-cycle result-ready pulse
//   o_stall     out  1     i_start & ~o_valid
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic [XLEN-1:0] o_result,
    output logic            o_valid,
    output logic            o_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*XLEN-1:0]   acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     opnd_q;    // mul: multiplicand magnitude; div: divisor magnitude
    logic [2:0]          op_q;
    logic                a_neg_q;
    logic                b_neg_q;

    // ------------------------------------------------------------------
    // Operand decode, evaluated in IDLE on the live inputs
    // ------------------------------------------------------------------
    logic            a_sgn, b_sgn;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            div_zero, div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned and a latch is never inferred.
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (i_funct3)
            3'b001, 3'b100, 3'b110: begin   // MULH, DIV, REM
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010: a_sgn = 1'b1;           // MULHSU: only rs1 signed
            default: ;                      // MUL low half is sign-agnostic
        endcase
    end

    assign a_neg_in = a_sgn & i_rs1_data[XLEN-1];
    assign b_neg_in = b_sgn & i_rs2_data[XLEN-1];
    assign a_mag_in = a_neg_in ? -i_rs1_data : i_rs1_data;
    assign b_mag_in = b_neg_in ? -i_rs2_data : i_rs2_data;

    assign div_zero = i_funct3[2] & (i_rs2_data == '0);
    // Only DIV/REM (funct3[0]=0) overflow: most-negative / -1
    assign div_ovf  = i_funct3[2] & ~i_funct3[0]
                    & (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                    & (i_rs2_data == {XLEN{1'b1}});

`ifdef FAST_MUL_EN
    // Each operand gets a 33rd bit that is either its sign or a zero, so one
    // signed multiplier covers all four multiply flavours.
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;

    assign fast_a    = {a_sgn & i_rs1_data[XLEN-1], i_rs1_data};
    assign fast_b    = {b_sgn & i_rs2_data[XLEN-1], i_rs2_data};
    assign fast_prod = (2*XLEN+2)'(fast_a) * (2*XLEN+2)'(fast_b);
`endif

    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (div_zero) begin
            special     = 1'b1;
            special_res = i_funct3[1] ? i_rs1_data : {XLEN{1'b1}};
        end else if (div_ovf) begin
            special     = 1'b1;
            special_res = i_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
`ifdef FAST_MUL_EN
        else if (!i_funct3[2]) begin
            special     = 1'b1;
            special_res = (i_funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                   : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                    + (acc[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Restoring divide: trial-subtract the divisor from the remainder with
    // the next dividend bit shifted in. A non-negative difference becomes
    // the new remainder and yields a quotient bit of 1.
    assign div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
    assign div_next = div_diff[XLEN+1] ? {acc[2*XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign acc_next = op_q[2] ? div_next : mul_next;

    // ------------------------------------------------------------------
    // Sign fixup on the final iteration's value
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        // Sign flags are zero for unsigned ops, so one rule fits all ops.
        prod_fix = (a_neg_q ^ b_neg_q) ? -acc_next : acc_next;
        quot_fix = (a_neg_q ^ b_neg_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix  = a_neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        if (op_q[2])
            final_res = op_q[1] ? rem_fix : quot_fix;
        else
            final_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                             : prod_fix[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_kill) begin
                        op_q    <= i_funct3;
                        a_neg_q <= a_neg_in;
                        b_neg_q <= b_neg_in;
                        if (special) begin
                            o_result <= special_res;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            acc    <= {{XLEN{1'b0}}, i_funct3[2] ? a_mag_in : b_mag_in};
                            opnd_q <= i_funct3[2] ? b_mag_in : a_mag_in;
                            cnt    <= CNT_W'(XLEN-1);
                            state  <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (i_kill) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            o_result <= final_res;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end

                // i_start is still high here from the finished instruction;
                // it is ignored and the unit always returns to IDLE.
                DONE:    state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

    assign o_stall = i_start & ~o_valid;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_kill;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] o_result;
    logic        o_valid;
    logic        o_stall;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_kill     (i_kill),
        .i_funct3   (i_funct3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_result   (o_result),
        .o_valid    (o_valid),
        .o_stall    (o_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sub, p;
        logic [63:0]        ua, ub, up;
        logic signed [31:0] a32, b32;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sub = ub;
        a32 = a;
        b32 = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin up = ua * ub;  return up[31:0];  end
            3'd1: begin p  = sa * sb;  return p[63:32];  end
            3'd2: begin p  = sa * sub; return p[63:32];  end
            3'd3: begin up = ua * ub;  return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return a32 / b32;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return a32 % b32;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0)) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Start one op at cycle 0, scramble the inputs after capture, and check
    // latency, result, stall behaviour, the one-cycle pulse and the hold.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        logic        stall_ok;
        exp_res  = ref_result(f3, a, b);
        exp_lat  = ref_latency(f3, a, b);
        lat      = -1;
        stall_ok = 1'b1;
        @(negedge i_clk);
        i_funct3   = f3;
        i_rs1_data = a;
        i_rs2_data = b;
        i_start    = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (o_valid === 1'b1) begin
                lat = c;
                break;
            end
            if (o_stall !== 1'b1) stall_ok = 1'b0;
            @(negedge i_clk);
            i_funct3   = 3'($urandom);
            i_rs1_data = $urandom;
            i_rs2_data = $urandom;
        end
        check({tag, " latency"},     32'(lat), 32'(exp_lat));
        check({tag, " result"},      o_result, exp_res);
        check({tag, " stall busy"},  32'(stall_ok), 32'd1);
        check({tag, " stall valid"}, 32'(o_stall), 32'd0);
        @(negedge i_clk);
        i_start = 1'b0;
        #1;
        check({tag, " valid pulse"}, 32'(o_valid), 32'd0);
        @(negedge i_clk);
        #1;
        check({tag, " hold"},        o_result, exp_res);
    endtask

    initial begin
        logic [31:0] prev;
        logic        saw_valid;

        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_kill     = 1'b0;
        i_funct3   = 3'd0;
        i_rs1_data = 32'h0;
        i_rs2_data = 32'h0;
        repeat (2) @(negedge i_clk);
        #1;
        check("reset valid",  32'(o_valid), 32'd0);
        check("reset result", o_result,     32'd0);
        check("reset stall",  32'(o_stall), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // MUL with a negative multiplier
        run_op("mul_7", 3'd0, 32'd7, 32'hFFFF_FFFD);

        // Asynchronous reset in the middle of an iterative op
        @(negedge i_clk);
        i_funct3   = 3'd5;
        i_rs1_data = 32'd1000;
        i_rs2_data = 32'd3;
        i_start    = 1'b1;
        repeat (10) @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("async rst valid",  32'(o_valid), 32'd0);
        check("async rst result", o_result,     32'd0);
        check("async rst stall",  32'(o_stall), 32'(i_start));
        @(negedge i_clk);
        i_start = 1'b0;
        i_rst   = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) saw_valid = 1'b1;
        end
        check("after rst no valid", 32'(saw_valid), 32'd0);

        // High-half multiplies
        run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_neg", 3'd2, 32'hFFFF_FFFF, 32'd2);

        // Divides with and without signs
        run_op("div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100", 3'd5, 32'd100, 32'd7);
        run_op("remu_100", 3'd7, 32'd100, 32'd7);

        // Special cases complete in cycle 1
        run_op("divu_by0", 3'd5, 32'd5, 32'd0);
        run_op("rem_by0",  3'd6, 32'd5, 32'd0);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Kill during a DIV at cycle 12, then kill beside start in IDLE
        prev = ref_result(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge i_clk);
        i_funct3   = 3'd4;
        i_rs1_data = 32'd12345;
        i_rs2_data = 32'hFFFF_FFF0;
        i_start    = 1'b1;
        repeat (12) @(negedge i_clk);
        i_kill = 1'b1;
        @(negedge i_clk);
        #1;
        check("kill no valid", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        i_start = 1'b0;
        i_kill  = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) saw_valid = 1'b1;
        end
        check("kill quiet",  32'(saw_valid), 32'd0);
        check("kill result", o_result, prev);
        run_op("div_after_kill", 3'd4, 32'd12345, 32'hFFFF_FFF0);

        // Randomised ops against the reference model
        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom), pick_operand(), pick_operand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
